serial_add_sequencer: RTL

//   Multi-cycle WIDTH-bit adder built around one two_bit_adder slice.

---
 rtl/serial_add_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// Digit-serial WIDTH-bit adder: one 2-bit adder slice driven LSB digit first,
// with the slice carry fed back through a flip-flop between digits.

module two_bit_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             step;
    logic             last;

    logic [1:0]       slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_nxt;

    two_bit_adder u_slice (
        .a    (a_sh[1:0]),
        .b    (b_sh[1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New digit enters at the top; after N steps digit 0 sits in sum[1:0].
    generate
        if (WIDTH == 2) begin : g_narrow
            assign sum_nxt = slice_s;
        end else begin : g_wide
            assign sum_nxt = {slice_s, sum[WIDTH-1:2]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept = start && (state == IDLE || state == DONE);
        step   = (state == RUN);
        last   = step && (cnt == LAST);
        busy   = (state == RUN);
        done   = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
            cout  <= 1'b0;
        end else if (step) begin
            a_sh  <= a_sh >> 2;
            b_sh  <= b_sh >> 2;
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
            sum   <= sum_nxt;
            if (last) cout <= slice_cout;
        end
    end

endmodule
